pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised, buffered successor to the fixed IF/ID pipeline register.
- Holds up to DEPTH in-flight words of DATA_WIDTH bits in a circular buffer with a valid/ready handshake on both sides.
- Keeps the global STALL (freeze) and FLUSH (bubble) controls from the hazard unit.
- Sits between any two pipeline stages, e.g. IF→ID with DATA_IN = {Instruction, InstructionAddressPlus4}, so a downstream stall does not immediately back-pressure fetch.

Parameters:
- DATA_WIDTH, 64, width of each buffered word.
- DEPTH, 2, number of entries; legal range 1..16; need not be a power of two.
- BUBBLE_VALUE, 0, value driven on DATA_OUT whenever the buffer is empty (NOP bubble).

Ports:
- CLOCK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
- STALL  in  1  hazard freeze; no push and no pop while high.
- FLUSH  in  1  hazard flush; empties the buffer at the next edge.
- IN_VALID  in  1  upstream word present.
- IN_READY  out  1  stage can accept a word this cycle.
- DATA_IN  in  DATA_WIDTH  upstream word.
- OUT_VALID  out  1  head entry valid.
- OUT_READY  in  1  downstream consumes the head this cycle.
- DATA_OUT  out  DATA_WIDTH  head entry, or BUBBLE_VALUE when empty.
- COUNT  out  $clog2(DEPTH+1)  current occupancy.
- FLUSH_DROPS  out  8  saturating count of valid entries discarded by flushes.

Behaviour:
- Reset is asynchronous, on the RESET falling edge / while RESET is low:
  - read/write pointers = 0, COUNT = 0, FLUSH_DROPS = 0.
  - OUT_VALID = 0, DATA_OUT = BUBBLE_VALUE, IN_READY = 0 while RESET is low.
  - Storage array contents are don't-care.
  - A reset mid-operation discards all entries with no partial state.
- Combinational outputs:
  - IN_READY = !STALL && (COUNT < DEPTH). There is no combinational path from OUT_READY to IN_READY.
  - OUT_VALID = (COUNT != 0).
  - DATA_OUT = OUT_VALID ? mem[rd_ptr] : BUBBLE_VALUE.
- Transfer conditions:
  - push = IN_VALID && IN_READY.
  - pop = OUT_VALID && OUT_READY && !STALL.
- Latency: a word pushed at edge N appears on DATA_OUT after edge N when the buffer was empty. Minimum latency is 1 cycle, matching the legacy register.
- Pointers:
  - On push, write mem[wr_ptr] and advance wr_ptr.
  - On pop, advance rd_ptr.
  - Pointers wrap from DEPTH-1 to 0, with an explicit compare (not a power-of-two mask).
- COUNT update: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
- Priority at each edge: FLUSH > STALL > push/pop.
  - FLUSH=1: pointers reset to 0 and COUNT set to 0; any same-cycle push and pop are discarded; FLUSH_DROPS += COUNT (pre-flush value), saturating at 255.
  - STALL=1 with FLUSH=0: all state frozen; DATA_OUT and OUT_VALID hold.
- Full (COUNT == DEPTH): IN_READY = 0; a pop frees one slot, visible as IN_READY = 1 the next cycle.
- Empty: DATA_OUT = BUBBLE_VALUE; OUT_READY is ignored.
- DEPTH = 1 degenerates to a single register with one bubble per transfer when full; this is legal.
- No $display or simulation-only side effects in the RTL.

Test Plan:
- Reset: assert RESET=0 mid-stream with COUNT=2 → COUNT=0, OUT_VALID=0, DATA_OUT=0, FLUSH_DROPS=0 immediately, without waiting for a clock edge.
- Fill/drain, DEPTH=2: push 0xA, 0xB with OUT_READY=0 → COUNT=2, IN_READY=0, DATA_OUT=0xA; then OUT_READY=1 for 2 cycles → DATA_OUT=0xB, then 0 with OUT_VALID=0.
- Stall: COUNT=1, STALL=1 for 3 cycles with IN_VALID=1 and OUT_READY=1 → IN_READY=0, COUNT stays 1, DATA_OUT unchanged; release → normal flow resumes.
- Flush priority: COUNT=2 with IN_VALID=1, OUT_READY=1, FLUSH=1 and STALL=1 in the same cycle → next cycle COUNT=0, DATA_OUT=0, FLUSH_DROPS=2; the input word is absent afterwards.
- Wrap, DEPTH=3: stream 10 words 1..10 with continuous push and pop → output order 1..10, no loss or duplication; pointers wrap 2→0 three times.
- Saturation: 130 flushes with COUNT=2 each → FLUSH_DROPS=255 and holds there.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
//
// Elastic pipeline stage that replaces a fixed IF/ID-style pipeline register.
// It is a DEPTH-entry circular buffer with a valid/ready handshake on both
// sides. When downstream stalls, upstream can keep filling free slots instead
// of stopping at once. The hazard-unit controls keep their meaning:
//   - STALL freezes the stage.
//   - FLUSH empties it and leaves a bubble.
//
// Ports
//   CLOCK        in   rising-edge clock
//   RESET        in   asynchronous, active-low reset
//   STALL        in   hazard freeze: no push and no pop while high
//   FLUSH        in   hazard flush: buffer empties at the next edge
//                     (wins over STALL)
//   IN_VALID     in   upstream word present
//   IN_READY     out  stage can take a word this cycle
//                     (independent of OUT_READY)
//   DATA_IN      in   upstream word
//   OUT_VALID    out  head entry valid
//   OUT_READY    in   downstream consumes the head this cycle
//   DATA_OUT     out  head entry, or BUBBLE_VALUE when empty
//   COUNT        out  current occupancy
//   FLUSH_DROPS  out  saturating count of valid entries thrown away by flushes
// -----------------------------------------------------------------------------
module pipe_stage_elastic #(
  parameter int unsigned           DATA_WIDTH   = 64,
  parameter int unsigned           DEPTH        = 2,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         STALL,
  input  logic                         FLUSH,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [DATA_WIDTH-1:0]        DATA_IN,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [DATA_WIDTH-1:0]        DATA_OUT,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT,
  output logic [7:0]                   FLUSH_DROPS
);

  // DEPTH = 1 would give a zero-width pointer; keep at least one bit.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Pointer advance with an explicit wrap so non power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Drop counter accumulate, clamped at 8'hFF.
  function automatic logic [7:0] drops_sat_add(input logic [7:0]       acc,
                                               input logic [CNT_W-1:0] n);
    logic [8:0] sum;
    sum = {1'b0, acc} + 9'(n);
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // State
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic [7:0]            drops_q,  drops_d;

  logic full_w;
  logic push_w;
  logic pop_w;
  logic write_en_w;

  // Handshake and outputs. IN_READY looks only at local state and STALL, so
  // there is no combinational path from OUT_READY back to IN_READY.
  assign full_w    = (count_q == FULL_CNT);
  assign IN_READY  = RESET && !STALL && !full_w;
  assign OUT_VALID = (count_q != '0);
  assign DATA_OUT  = OUT_VALID ? mem_q[rd_ptr_q] : BUBBLE_VALUE;

  assign COUNT       = count_q;
  assign FLUSH_DROPS = drops_q;

  assign push_w = IN_VALID && IN_READY;
  assign pop_w  = OUT_VALID && OUT_READY && !STALL;

  // A flush discards a same-cycle push, so the slot is not written.
  assign write_en_w = push_w && !FLUSH;

  // Next-state: FLUSH over STALL over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drops_d  = drops_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drops_d  = drops_sat_add(drops_q, count_q);
    end else if (!STALL) begin
      if (push_w) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_w)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_w && !pop_w) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_w && !push_w) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control registers
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drops_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drops_q  <= drops_d;
    end
  end

  // Storage: no reset, an entry is only visible once COUNT covers it.
  always_ff @(posedge CLOCK) begin
    if (write_en_w) begin
      mem_q[wr_ptr_q] <= DATA_IN;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Two instances share one stimulus stream:
//   - instance 0 has DEPTH 2.
//   - instance 1 has DEPTH 3.
// Each instance has its own reference model, which is an ordered queue of
// accepted words plus a drop tally. A monitor compares every observable
// output against that model on the falling clock edge. Directed sequences
// add explicit checks against literal values for the key scenarios.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

  localparam int DW = 32;

  logic          CLOCK;
  logic          RESET;
  logic          STALL;
  logic          FLUSH;
  logic          IN_VALID;
  logic          OUT_READY;
  logic [DW-1:0] DATA_IN;

  logic          in_rdy  [2];
  logic          out_vld [2];
  logic [DW-1:0] dout    [2];
  logic [1:0]    cnt     [2];
  logic [7:0]    drops   [2];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] wlog [$];
  bit            log_en = 0;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input int inst, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL d%0d %s: got %0h expected %0h at %0t",
               inst, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = g + 2;

    logic [DW-1:0] mq [$];
    int unsigned   mdrops;

    pipe_stage_elastic #(
      .DATA_WIDTH (DW),
      .DEPTH      (D)
    ) u_dut (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .STALL       (STALL),
      .FLUSH       (FLUSH),
      .IN_VALID    (IN_VALID),
      .IN_READY    (in_rdy[g]),
      .DATA_IN     (DATA_IN),
      .OUT_VALID   (out_vld[g]),
      .OUT_READY   (OUT_READY),
      .DATA_OUT    (dout[g]),
      .COUNT       (cnt[g]),
      .FLUSH_DROPS (drops[g])
    );

    // Reference model: queue of words in arrival order.
    always @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
        mq.delete();
        mdrops <= 0;
      end else if (FLUSH) begin
        mdrops <= (mdrops + mq.size() > 255) ? 255 : mdrops + mq.size();
        mq.delete();
      end else if (!STALL) begin
        if (IN_VALID && mq.size() < D) begin
          if (OUT_READY && mq.size() != 0) void'(mq.pop_front());
          mq.push_back(DATA_IN);
        end else if (OUT_READY && mq.size() != 0) begin
          void'(mq.pop_front());
        end
      end
    end

    // Monitor: compare DUT against model away from the active edge.
    always @(negedge CLOCK) begin
      if (RESET) begin
        chk(g, "count",    64'(cnt[g]),     64'(mq.size()));
        chk(g, "out_valid",64'(out_vld[g]), 64'(mq.size() != 0));
        chk(g, "data_out", 64'(dout[g]),
            (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
        chk(g, "in_ready", 64'(in_rdy[g]),  64'(!STALL && mq.size() < D));
        chk(g, "drops",    64'(drops[g]),   64'(mdrops));
        if (g == 1 && log_en && OUT_READY && !STALL && !FLUSH &&
            mq.size() != 0) begin
          wlog.push_back(dout[g]);
        end
      end
    end
  end

  task automatic drive(input logic iv, input logic [DW-1:0] d,
                       input logic ordy, input logic st, input logic fl);
    IN_VALID  = iv;
    DATA_IN   = d;
    OUT_READY = ordy;
    STALL     = st;
    FLUSH     = fl;
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    IN_VALID = 1'b0; OUT_READY = 1'b0; DATA_IN = '0;
    repeat (2) @(posedge CLOCK);
    #1;

    // Reset state
    for (int i = 0; i < 2; i++) begin
      chk(i, "rst_in_ready",  64'(in_rdy[i]),  64'd0);
      chk(i, "rst_out_valid", 64'(out_vld[i]), 64'd0);
      chk(i, "rst_data_out",  64'(dout[i]),    64'd0);
      chk(i, "rst_count",     64'(cnt[i]),     64'd0);
      chk(i, "rst_drops",     64'(drops[i]),   64'd0);
    end
    RESET = 1'b1;

    // Fill and drain
    drive(1, 32'hA, 0, 0, 0);
    drive(1, 32'hB, 0, 0, 0);
    chk(0, "fill_count",    64'(cnt[0]),    64'd2);
    chk(0, "fill_in_ready", 64'(in_rdy[0]), 64'd0);
    chk(0, "fill_head",     64'(dout[0]),   64'hA);
    drive(0, 0, 1, 0, 0);
    chk(0, "drain1_head", 64'(dout[0]), 64'hB);
    drive(0, 0, 1, 0, 0);
    chk(0, "drain2_head",  64'(dout[0]),    64'd0);
    chk(0, "drain2_valid", 64'(out_vld[0]), 64'd0);

    // Stall
    drive(1, 32'h11, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h22, 1, 1, 0);
      chk(0, "stall_in_ready", 64'(in_rdy[0]), 64'd0);
      chk(0, "stall_count",    64'(cnt[0]),    64'd1);
      chk(0, "stall_head",     64'(dout[0]),   64'h11);
    end
    drive(1, 32'h22, 1, 0, 0);
    chk(0, "resume_head",  64'(dout[0]), 64'h22);
    chk(0, "resume_count", 64'(cnt[0]),  64'd1);
    drive(0, 0, 1, 0, 0);

    // Flush beats stall, push and pop
    drive(1, 32'h1, 0, 0, 0);
    drive(1, 32'h2, 0, 0, 0);
    drive(1, 32'h33, 1, 1, 1);
    for (int i = 0; i < 2; i++) begin
      chk(i, "flush_count", 64'(cnt[i]),   64'd0);
      chk(i, "flush_head",  64'(dout[i]),  64'd0);
      chk(i, "flush_drops", 64'(drops[i]), 64'd2);
    end
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++)
      chk(i, "flush_no_word", 64'(out_vld[i]), 64'd0);

    // Wrap on DEPTH 3: stream 1..10 with continuous push and pop
    wlog.delete();
    log_en = 1;
    for (int k = 1; k <= 10; k++) drive(1, DW'(k), 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    log_en = 0;
    chk(1, "wrap_len", 64'(wlog.size()), 64'd10);
    for (int k = 0; k < 10; k++)
      if (k < wlog.size()) chk(1, "wrap_word", 64'(wlog[k]), 64'(k + 1));

    // Asynchronous reset mid-stream
    drive(1, 32'h44, 0, 0, 0);
    drive(1, 32'h55, 0, 0, 0);
    IN_VALID = 1'b0;
    chk(0, "pre_rst_count", 64'(cnt[0]), 64'd2);
    #2;
    RESET = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(i, "arst_count",     64'(cnt[i]),     64'd0);
      chk(i, "arst_out_valid", 64'(out_vld[i]), 64'd0);
      chk(i, "arst_data_out",  64'(dout[i]),    64'd0);
      chk(i, "arst_drops",     64'(drops[i]),   64'd0);
      chk(i, "arst_in_ready",  64'(in_rdy[i]),  64'd0);
    end
    RESET = 1'b1;

    // Drop counter saturation
    for (int k = 0; k < 130; k++) begin
      drive(1, DW'(k), 0, 0, 0);
      drive(1, DW'(k + 1000), 0, 0, 0);
      drive(0, 0, 0, 0, 1);
    end
    for (int i = 0; i < 2; i++) chk(i, "sat_drops", 64'(drops[i]), 64'd255);
    drive(1, 32'h77, 0, 0, 0);
    drive(1, 32'h78, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) chk(i, "sat_hold", 64'(drops[i]), 64'd255);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
            ($urandom % 8) == 0, ($urandom % 20) == 0);
    end
    drive(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
